gfx_fb_writer: RTL and testbench

Downstream consumer of the graphics pixel generators (clear, line, fill). Accepts one `(x, y, color)` pixel per valid/ready handshake and converts it to a linear framebuffer address, `y*FB_WIDTH + x`. Buffers the write in a small FIFO and presents it to the SRAM write port of the framebuffer arbiter. Its `gfx_ready` drives the generator's `inc`. It reports completion when the write tagged `last` has been accepted by memory.

---
 rtl/gfx_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 51 +++++
 rtl/gfx_fb_writer.sv | 105 ++++++++++
 tb/tb_gfx_fb_writer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared types and helpers for the graphics framebuffer write path.
// fb_write_t describes one buffered write at the default framebuffer geometry.
package gfx_pkg;

  localparam int FB_DEF_WIDTH      = 640;
  localparam int FB_DEF_HEIGHT     = 480;
  localparam int FB_DEF_PIXEL_BITS = 12;
  localparam int FB_DEF_ADDR_BITS  = 20;

  // Minimum linear-address width for a w x h framebuffer.
  function automatic int fb_addr_bits(input int w, input int h);
    return $clog2(w * h);
  endfunction

  typedef struct packed {
    logic                        last;
    logic [FB_DEF_ADDR_BITS-1:0]  addr;
    logic [FB_DEF_PIXEL_BITS-1:0] data;
  } fb_write_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth; pointers wrap naturally.
// A push into a full FIFO is honoured only when a pop happens in the same cycle.
module sync_fifo
  import gfx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w_inc,
  input  logic [WIDTH-1:0] w_data,
  input  logic             r_inc,
  output logic [WIDTH-1:0] r_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_w, do_r;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign do_r  = r_inc & ~empty;
  assign do_w  = w_inc & (~full | do_r);
  assign r_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_w) mem_q[wr_ptr_q] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_w) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_r) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_w && !do_r)      count_q <= count_q + CW'(1);
      else if (do_r && !do_w) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/gfx_fb_writer.sv
// Converts (x, y, color) pixels into linear framebuffer writes through a
// one-stage register and a small write FIFO; pulses done after each last write.
module gfx_fb_writer
  import gfx_pkg::*;
#(
  parameter int FB_WIDTH   = FB_DEF_WIDTH,
  parameter int FB_HEIGHT  = FB_DEF_HEIGHT,
  parameter int PIXEL_BITS = FB_DEF_PIXEL_BITS,
  parameter int ADDR_BITS  = FB_DEF_ADDR_BITS,
  parameter int FIFO_DEPTH = 4,
  localparam int FB_X_BITS = $clog2(FB_WIDTH),
  localparam int FB_Y_BITS = $clog2(FB_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  gfx_valid,
  input  logic [FB_X_BITS-1:0]  gfx_x,
  input  logic [FB_Y_BITS-1:0]  gfx_y,
  input  logic [PIXEL_BITS-1:0] gfx_color,
  input  logic                  gfx_last,
  output logic                  gfx_ready,
  output logic                  mem_wr_valid,
  output logic [ADDR_BITS-1:0]  mem_wr_addr,
  output logic [PIXEL_BITS-1:0] mem_wr_data,
  input  logic                  mem_wr_ready,
  output logic                  done
);

  // Handshakes: a transfer happens in any cycle where valid and ready are both
  // high; valid never waits on ready, and ready depends on registered state only.
  localparam int WORD_W = 1 + ADDR_BITS + PIXEL_BITS;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FB_X_BITS:0] X_LIM = (FB_X_BITS + 1)'(FB_WIDTH);
  localparam logic [FB_Y_BITS:0] Y_LIM = (FB_Y_BITS + 1)'(FB_HEIGHT);

  logic                  s1_valid_q, s1_drop_q, s1_last_q;
  logic [ADDR_BITS-1:0]  s1_addr_q, s1_addr_d;
  logic [PIXEL_BITS-1:0] s1_data_q;
  logic                  s1_drop_d;
  logic                  done_q, done_d;
  logic                  accept, push, pop;
  logic                  head_last;
  logic [WORD_W-1:0]     fifo_wdata, fifo_rdata;
  logic                  fifo_empty, unused_fifo_full;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           occupancy;

  assign occupancy = {1'b0, fifo_count} + (CW + 1)'(s1_valid_q);
  assign gfx_ready = (occupancy < (CW + 1)'(FIFO_DEPTH));
  assign accept    = gfx_valid & gfx_ready;

  assign s1_addr_d = ADDR_BITS'(gfx_y) * ADDR_BITS'(FB_WIDTH) + ADDR_BITS'(gfx_x);
  assign s1_drop_d = ({1'b0, gfx_x} >= X_LIM) | ({1'b0, gfx_y} >= Y_LIM);

  always_ff @(posedge clk) begin
    if (reset) s1_valid_q <= 1'b0;
    else       s1_valid_q <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_addr_q <= s1_addr_d;
      s1_data_q <= gfx_color;
      s1_last_q <= gfx_last;
      s1_drop_q <= s1_drop_d;
    end
  end

  assign push       = s1_valid_q & ~s1_drop_q;
  assign fifo_wdata = {s1_last_q, s1_addr_q, s1_data_q};

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .w_inc  (push),
    .w_data (fifo_wdata),
    .r_inc  (pop),
    .r_data (fifo_rdata),
    .full   (unused_fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign mem_wr_valid = ~fifo_empty;
  assign {head_last, mem_wr_addr, mem_wr_data} = fifo_rdata;
  assign pop = mem_wr_valid & mem_wr_ready;

  // A dropped last pixel completes as it leaves stage 1, since nothing reaches memory.
  always_comb begin
    done_d = 1'b0;
    if (pop && head_last)                   done_d = 1'b1;
    if (s1_valid_q && s1_drop_q && s1_last_q) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= done_d;
  end

  assign done = done_q;

endmodule

// File: tb/tb_gfx_fb_writer.sv
// Randomised bench for gfx_fb_writer against a transaction-level model:
// expected writes in order, per-pixel acceptance latency and scheduled done cycles.
module tb_gfx_fb_writer;
  import gfx_pkg::*;

  localparam int W  = 640;
  localparam int H  = 480;
  localparam int D  = 4;
  localparam int XB = $clog2(W);
  localparam int YB = $clog2(H);
  localparam int AB = fb_addr_bits(W, H) + 1;
  localparam int PB = 12;
  localparam int EW = $bits(fb_write_t);

  logic          clk = 1'b0;
  logic          reset;
  logic          gfx_valid;
  logic [XB-1:0] gfx_x;
  logic [YB-1:0] gfx_y;
  logic [PB-1:0] gfx_color;
  logic          gfx_last;
  logic          gfx_ready;
  logic          mem_wr_valid;
  logic [AB-1:0] mem_wr_addr;
  logic [PB-1:0] mem_wr_data;
  logic          mem_wr_ready;
  logic          done;

  gfx_fb_writer #(
    .FB_WIDTH   (W),
    .FB_HEIGHT  (H),
    .PIXEL_BITS (PB),
    .ADDR_BITS  (AB),
    .FIFO_DEPTH (D)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .gfx_valid    (gfx_valid),
    .gfx_x        (gfx_x),
    .gfx_y        (gfx_y),
    .gfx_color    (gfx_color),
    .gfx_last     (gfx_last),
    .gfx_ready    (gfx_ready),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_ready (mem_wr_ready),
    .done         (done)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard state
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [EW-1:0] exp_q[$];
  int            exp_t[$];
  bit            done_at[int];
  bit            drop_in_s1 = 1'b0;
  int            wr_cnt = 0, rdy_cnt = 0, dn_cnt = 0;
  logic          stall_prev = 1'b0;
  logic [AB-1:0] prev_addr;
  logic [PB-1:0] prev_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: check outputs at the negedge, drive inputs, advance the model.
  task automatic step(input logic rst, input logic v, input int x, input int y,
                      input logic [PB-1:0] c, input logic l, input logic mr,
                      output bit acc);
    fb_write_t head;
    logic      exp_rdy, exp_mv;
    exp_rdy = (exp_q.size() + int'(drop_in_s1)) < D;
    exp_mv  = 1'b0;
    if (exp_q.size() > 0) exp_mv = (exp_t[0] + 2 <= cyc);
    check("gfx_ready", 32'(gfx_ready), 32'(exp_rdy));
    check("mem_wr_valid", 32'(mem_wr_valid), 32'(exp_mv));
    check("done", 32'(done), 32'(done_at.exists(cyc)));
    if (exp_mv) begin
      head = fb_write_t'(exp_q[0]);
      check("wr_addr", 32'(mem_wr_addr), 32'(head.addr));
      check("wr_data", 32'(mem_wr_data), 32'(head.data));
      if (stall_prev) begin
        check("stable_addr", 32'(mem_wr_addr), 32'(prev_addr));
        check("stable_data", 32'(mem_wr_data), 32'(prev_data));
      end
    end
    if (mem_wr_valid && mr && !rst) wr_cnt++;
    if (gfx_ready && v && !rst) rdy_cnt++;
    if (done) dn_cnt++;
    stall_prev = exp_mv && !mr && !rst;
    prev_addr  = mem_wr_addr;
    prev_data  = mem_wr_data;

    reset        = rst;
    gfx_valid    = v;
    gfx_x        = XB'(x);
    gfx_y        = YB'(y);
    gfx_color    = c;
    gfx_last     = l;
    mem_wr_ready = mr;

    acc = 1'b0;
    if (done_at.exists(cyc)) done_at.delete(cyc);
    if (rst) begin
      exp_q.delete();
      exp_t.delete();
      done_at.delete();
      drop_in_s1 = 1'b0;
    end else begin
      if (exp_mv && mr) begin
        head = fb_write_t'(exp_q.pop_front());
        void'(exp_t.pop_front());
        if (head.last) done_at[cyc + 1] = 1'b1;
      end
      drop_in_s1 = 1'b0;
      if (v && exp_rdy) begin
        acc = 1'b1;
        if (x < W && y < H) begin
          head.last = l;
          head.addr = FB_DEF_ADDR_BITS'(y * W + x);
          head.data = c;
          exp_q.push_back(EW'(head));
          exp_t.push_back(cyc);
        end else begin
          drop_in_s1 = 1'b1;
          if (l) done_at[cyc + 2] = 1'b1;
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n, input logic mr);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, '0, 1'b0, mr, acc);
  endtask

  initial begin
    bit acc;
    int base, rbase, dbase, k, n, guard, tries;
    reset = 1'b1; gfx_valid = 1'b0; gfx_x = '0; gfx_y = '0;
    gfx_color = '0; gfx_last = 1'b0; mem_wr_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Clear a 4x3 region with free-running memory
    base = wr_cnt; dbase = dn_cnt;
    for (int yy = 0; yy < 3; yy++) begin
      for (int xx = 0; xx < 4; xx++) begin
        tries = 0;
        do begin
          step(1'b0, 1'b1, xx, yy, '0, (xx == 3 && yy == 2), 1'b1, acc);
          tries++;
        end while (!acc && tries < 50);
        if (!acc) check("clear_accept_timeout", 32'(acc), 32'd1);
      end
    end
    idle(5, 1'b1);
    check("clear_writes", 32'(wr_cnt - base), 32'd12);
    check("clear_done_pulses", 32'(dn_cnt - dbase), 32'd1);

    // Backpressure: memory stalled for 10 cycles
    base = wr_cnt; rbase = rdy_cnt; k = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, k, 0, PB'(k + 16), (k == 3), 1'b0, acc);
      if (acc) k++;
    end
    check("bp_accepts", 32'(rdy_cnt - rbase), 32'd4);
    check("bp_no_writes", 32'(wr_cnt - base), 32'd0);
    idle(8, 1'b1);
    check("bp_drain_writes", 32'(wr_cnt - base), 32'd4);

    // Out-of-range pixels are dropped, last still completes
    base = wr_cnt; dbase = dn_cnt;
    step(1'b0, 1'b1, 640, 0, 12'h111, 1'b1, 1'b1, acc);
    idle(1, 1'b1);
    step(1'b0, 1'b1, 0, 480, 12'h222, 1'b0, 1'b1, acc);
    step(1'b0, 1'b1, 700, 500, 12'h333, 1'b1, 1'b1, acc);
    idle(5, 1'b1);
    check("drop_writes", 32'(wr_cnt - base), 32'd0);
    check("drop_done_pulses", 32'(dn_cnt - dbase), 32'd2);

    // Corner address
    step(1'b0, 1'b1, 639, 479, 12'hABC, 1'b0, 1'b0, acc);
    idle(1, 1'b0);
    check("corner_addr", 32'(mem_wr_addr), 32'd307199);
    check("corner_data", 32'(mem_wr_data), 32'hABC);
    idle(3, 1'b1);

    // Reset while the FIFO is full
    dbase = dn_cnt; k = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, k, 2, PB'(k + 32), (k == 2), 1'b0, acc);
      if (acc) k++;
    end
    step(1'b1, 1'b0, 0, 0, '0, 1'b0, 1'b0, acc);
    check("rst_mem_wr_valid", 32'(mem_wr_valid), 32'd0);
    check("rst_gfx_ready", 32'(gfx_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    step(1'b0, 1'b1, 1, 1, 12'h5A5, 1'b1, 1'b0, acc);
    idle(1, 1'b0);
    check("post_rst_addr", 32'(mem_wr_addr), 32'd641);
    idle(4, 1'b1);
    check("rst_done_pulses", 32'(dn_cnt - dbase), 32'd1);

    // Random stall on both sides over 1000 pixels
    n = 0; guard = 0;
    while (n < 1000 && guard < 20000) begin
      step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 700)),
           int'($urandom_range(0, 500)), PB'($urandom_range(0, 4095)),
           ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), acc);
      if (acc) n++;
      guard++;
    end
    check("random_pixels", 32'(n), 32'd1000);
    idle(20, 1'b1);
    check("final_idle", 32'(mem_wr_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
